// File: rtl/cdr_pkg.sv
// Shared types and constants for the CDR step controller: FSM states,
// step direction encoding and the bang-bang vote decode.
package cdr_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } cdr_state_t;

    typedef logic cdr_dir_t;
    localparam cdr_dir_t DIR_UP = 1'b1;
    localparam cdr_dir_t DIR_DN = 1'b0;

    localparam logic signed [1:0] VOTE_UP   = 2'sb01;
    localparam logic signed [1:0] VOTE_DN   = 2'sb11;
    localparam logic signed [1:0] VOTE_NONE = 2'sb00;

    // Conflicting or absent detector outputs carry no information.
    function automatic logic signed [1:0] vote_decode(input logic early, input logic late);
        logic signed [1:0] v;
        v = VOTE_NONE;
        if (late && !early)
            v = VOTE_UP;
        else if (early && !late)
            v = VOTE_DN;
        return v;
    endfunction

endpackage

// File: rtl/cdr_vote_accum.sv
// Signed early/late vote accumulator with threshold detect; the accumulator
// returns to zero whenever a threshold is reached or the controller is busy.
module cdr_vote_accum
    import cdr_pkg::*;
#(
    parameter int THRESH = 4
) (
    input  logic ref_clk,
    input  logic rst,
    input  logic accept,
    input  logic clear,
    input  logic early,
    input  logic late,
    output logic hit_up,
    output logic hit_dn
);

    localparam int AW = $clog2(THRESH) + 2;
    localparam logic signed [AW-1:0] POS_T = AW'(THRESH);
    localparam logic signed [AW-1:0] NEG_T = -AW'(THRESH);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] next_acc;
    logic signed [AW-1:0] delta;

    always_comb begin
        delta    = AW'(vote_decode(early, late));
        next_acc = acc + delta;
    end

    // Threshold is only reachable one vote at a time, so acc stays within +/-THRESH.
    assign hit_up = accept && (next_acc == POS_T);
    assign hit_dn = accept && (next_acc == NEG_T);

    always_ff @(posedge ref_clk) begin
        if (rst || clear)
            acc <= '0;
        else if (accept)
            acc <= (hit_up || hit_dn) ? '0 : next_acc;
    end

endmodule

// File: rtl/cdr_step_controller.sv
// CDR phase-rotator loop controller: vote accumulation, step/settle FSM,
// phase pointer. Optional lock detector enabled by defining CDR_LOCK_DET_EN.
module cdr_step_controller
    import cdr_pkg::*;
#(
    parameter int THRESH     = 4,
    parameter int SETTLE_CYC = 8,
    parameter int NPHASE     = 8,
    parameter int LOCK_CNT   = 4
) (
    input  logic                        ref_clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        early,
    input  logic                        late,
    output logic                        inc,
    output logic                        dec,
    output logic                        busy,
    output logic [$clog2(NPHASE)-1:0]   phase_idx,
    output logic                        lock
);

    localparam int PW  = $clog2(NPHASE);
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    cdr_state_t     state;
    logic [SCW-1:0] settle_cnt;
    logic           accept;
    logic           clear;
    logic           hit_up;
    logic           hit_dn;

    assign accept = (state == ACCUM) && en;
    assign clear  = (state != ACCUM);

    cdr_vote_accum #(
        .THRESH (THRESH)
    ) u_accum (
        .ref_clk (ref_clk),
        .rst     (rst),
        .accept  (accept),
        .clear   (clear),
        .early   (early),
        .late    (late),
        .hit_up  (hit_up),
        .hit_dn  (hit_dn)
    );

    // Step pulses and the phase pointer move on the edge that samples the
    // threshold vote, so the rotator sees the step one cycle after that vote.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state      <= ACCUM;
            inc        <= 1'b0;
            dec        <= 1'b0;
            busy       <= 1'b0;
            phase_idx  <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (hit_up || hit_dn) begin
                        state     <= STEP;
                        busy      <= 1'b1;
                        inc       <= hit_up;
                        dec       <= hit_dn;
                        phase_idx <= hit_up ? phase_idx + PW'(1) : phase_idx - PW'(1);
                    end
                end
                STEP: begin
                    state      <= SETTLE;
                    inc        <= 1'b0;
                    dec        <= 1'b0;
                    settle_cnt <= SETTLE_LAST;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ACCUM;
                        busy  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - SCW'(1);
                    end
                end
                default: begin
                    state <= ACCUM;
                    inc   <= 1'b0;
                    dec   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CDR_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_CNT + 1);

    logic          step_fire;
    cdr_dir_t      step_dir;
    cdr_dir_t      prev_dir;
    logic          have_prev;
    logic [LW-1:0] alt_cnt;

    assign step_fire = hit_up || hit_dn;
    assign step_dir  = hit_up ? DIR_UP : DIR_DN;

    // The first step after reset has nothing to alternate against.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            prev_dir  <= DIR_DN;
            have_prev <= 1'b0;
            alt_cnt   <= '0;
            lock      <= 1'b0;
        end else if (step_fire) begin
            prev_dir  <= step_dir;
            have_prev <= 1'b1;
            if (have_prev && (step_dir == prev_dir)) begin
                alt_cnt <= '0;
                lock    <= 1'b0;
            end else if (have_prev) begin
                if (alt_cnt < LW'(LOCK_CNT))
                    alt_cnt <= alt_cnt + LW'(1);
                if (alt_cnt >= LW'(LOCK_CNT - 1))
                    lock <= 1'b1;
            end
        end
    end
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_step_controller.sv
// Directed bench for cdr_step_controller with default parameters.
module tb_cdr_step_controller;

`ifdef CDR_LOCK_DET_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic       ref_clk;
    logic       rst;
    logic       en;
    logic       early;
    logic       late;
    logic       inc;
    logic       dec;
    logic       busy;
    logic [2:0] phase_idx;
    logic       lock;

    int n_vec = 0;
    int n_err = 0;

    cdr_step_controller dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .en        (en),
        .early     (early),
        .late      (late),
        .inc       (inc),
        .dec       (dec),
        .busy      (busy),
        .phase_idx (phase_idx),
        .lock      (lock)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; early = 1'b0; late = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One step burst: THRESH votes one way, then idle through settle.
    task automatic burst(input bit up, input bit exp_lock, input int exp_phase);
        en = 1'b1; late = up; early = !up;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("burst_pre_inc", inc, 0);
            chk("burst_pre_dec", dec, 0);
        end
        tick();
        chk("burst_inc", inc, up);
        chk("burst_dec", dec, !up);
        chk("burst_phase", phase_idx, exp_phase);
        chk("burst_lock", lock, exp_lock && LOCK_ON);
        late = 1'b0; early = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("burst_idle_busy", busy, 0);
        chk("burst_idle_lock", lock, exp_lock && LOCK_ON);
    endtask

    initial begin
        int steps;
        rst = 1'b0; en = 1'b0; early = 1'b0; late = 1'b0;

        // Reset state
        do_reset();
        chk("rst_inc", inc, 0);
        chk("rst_dec", dec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_phase", phase_idx, 0);
        chk("rst_lock", lock, 0);
        chk("rst_acc", dut.u_accum.acc, 0);

        // Constant late: inc every 13 cycles from cycle 4, phase wraps 7 -> 0
        en = 1'b1; late = 1'b1;
        for (int k = 1; k <= 108; k++) begin
            tick();
            steps = (k >= 4) ? (k - 4) / 13 + 1 : 0;
            chk("late_inc", inc, ((k >= 4) && ((k - 4) % 13 == 0)) ? 1 : 0);
            chk("late_busy", busy, ((k >= 4) && ((k - 4) % 13 <= 8)) ? 1 : 0);
            chk("late_dec", dec, 0);
            chk("late_phase", phase_idx, steps % 8);
        end

        // Constant early: dec every 13 cycles, phase 0 -> 7 -> 6 -> 5
        do_reset();
        en = 1'b1; early = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            steps = (k >= 4) ? (k - 4) / 13 + 1 : 0;
            chk("early_dec", dec, ((k >= 4) && ((k - 4) % 13 == 0)) ? 1 : 0);
            chk("early_inc", inc, 0);
            chk("early_phase", phase_idx, (8 - steps % 8) % 8);
        end

        // Vote sequence L,L,E,L,L,L -> acc 1,2,1,2,3 then inc
        do_reset();
        en = 1'b1;
        early = 1'b0; late = 1'b1; tick(); chk("seq_acc1", dut.u_accum.acc, 1);
        tick(); chk("seq_acc2", dut.u_accum.acc, 2);
        early = 1'b1; late = 1'b0; tick(); chk("seq_acc3", dut.u_accum.acc, 1);
        early = 1'b0; late = 1'b1; tick(); chk("seq_acc4", dut.u_accum.acc, 2);
        tick(); chk("seq_acc5", dut.u_accum.acc, 3);
        chk("seq_inc_early", inc, 0);
        tick();
        chk("seq_inc", inc, 1);
        chk("seq_acc_clr", dut.u_accum.acc, 0);
        chk("seq_phase", phase_idx, 1);
        early = 1'b1; late = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("settle_busy", busy, 1);
            chk("settle_inc", inc, 0);
            chk("settle_dec", dec, 0);
            chk("settle_acc", dut.u_accum.acc, 0);
        end
        tick();
        chk("settle_exit_busy", busy, 0);
        chk("settle_exit_acc", dut.u_accum.acc, 0);
        chk("settle_exit_dec", dec, 0);
        early = 1'b0;

        // Neutral votes and en=0 hold acc
        do_reset();
        en = 1'b1; late = 1'b1;
        tick(); tick();
        chk("hold_acc_pre", dut.u_accum.acc, 2);
        early = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            chk("both_inc", inc, 0);
            chk("both_dec", dec, 0);
            chk("both_busy", busy, 0);
        end
        chk("both_acc", dut.u_accum.acc, 2);
        early = 1'b0; en = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            chk("dis_inc", inc, 0);
            chk("dis_busy", busy, 0);
        end
        chk("dis_acc", dut.u_accum.acc, 2);

        // Resume, then reset in the middle of settle
        en = 1'b1;
        tick(); chk("resume_acc", dut.u_accum.acc, 3);
        tick(); chk("resume_inc", inc, 1);
        late = 1'b0;
        tick(); tick(); tick();
        chk("mid_settle_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_settle_busy", busy, 0);
        chk("rst_settle_phase", phase_idx, 0);
        chk("rst_settle_acc", dut.u_accum.acc, 0);

        // Reset while the inc pulse is visible
        late = 1'b1;
        tick(); tick(); tick(); tick();
        chk("pre_rst_step_inc", inc, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_step_inc", inc, 0);
        chk("rst_step_busy", busy, 0);
        chk("rst_step_phase", phase_idx, 0);
        late = 1'b0;

        // Alternating bursts then a repeated direction
        do_reset();
        burst(1'b1, 1'b0, 1);
        burst(1'b0, 1'b0, 0);
        burst(1'b1, 1'b0, 1);
        burst(1'b0, 1'b0, 0);
        burst(1'b1, 1'b1, 1);
        burst(1'b1, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
